// File: rtl/direction_input_conditioner.sv
// Direction button front end: 2-flop sync, per-button debounce, and a gesture FSM
// that emits at most one registered move pulse (or CONFLICT) per press gesture.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// ST_LOCKOUT | post-reset settle; debouncers fill, no pulses issued
// ST_IDLE    | waiting for a qualifying press
// ST_HELD    | gesture consumed; wait until every debounced button is released
module direction_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n,
  input  logic btn_s,
  input  logic btn_e,
  input  logic btn_w,
  output logic N,
  output logic S,
  output logic E,
  output logic W,
  output logic CONFLICT
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 3);
  localparam logic [CW-1:0] ONE     = CW'(1);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LO_LAST = CW'(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {ST_LOCKOUT, ST_IDLE, ST_HELD} state_t;

  // Bit order everywhere: [3]=N, [2]=S, [1]=E, [0]=W
  logic [3:0]         w_btn;
  logic [3:0]         r_s1, r_s2, r_db, w_db_nxt;
  logic [3:0][CW-1:0] r_cnt, w_cnt_nxt;
  logic [CW-1:0]      r_lo_cnt, w_lo_nxt;
  state_t             r_state, w_state_nxt;
  logic [3:0]         r_pulse, w_pulse_nxt;
  logic               r_conflict, w_conflict_nxt;

  assign w_btn = {btn_n, btn_s, btn_e, btn_w};

  always_comb begin
    w_db_nxt  = r_db;
    w_cnt_nxt = '0;
    for (int i = 0; i < 4; i++) begin
      if (r_s2[i] != r_db[i]) begin
        if (r_cnt[i] + ONE == DB_LAST) begin
          w_db_nxt[i] = r_s2[i];
        end else begin
          w_cnt_nxt[i] = r_cnt[i] + ONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1  <= '0;
      r_s2  <= '0;
      r_db  <= '0;
      r_cnt <= '0;
    end else begin
      r_s1  <= w_btn;
      r_s2  <= r_s1;
      r_db  <= w_db_nxt;
      r_cnt <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_lo_nxt       = r_lo_cnt;
    w_pulse_nxt    = '0;
    w_conflict_nxt = 1'b0;
    case (r_state)
      ST_LOCKOUT: begin
        if (r_lo_cnt == LO_LAST) begin
          w_lo_nxt = '0;
          // Use the level db takes on this edge so a button held through reset,
          // qualifying on the expiry edge itself, is absorbed rather than pulsed.
          w_state_nxt = (|w_db_nxt) ? ST_HELD : ST_IDLE;
        end else begin
          w_lo_nxt = r_lo_cnt + ONE;
        end
      end
      ST_IDLE: begin
        if (|r_db) begin
          w_state_nxt = ST_HELD;
          if ($onehot(r_db)) begin
            w_pulse_nxt = r_db;
          end else begin
            w_conflict_nxt = 1'b1;
          end
        end
      end
      ST_HELD: begin
        if (r_db == 4'b0000) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_LOCKOUT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_LOCKOUT;
      r_lo_cnt   <= '0;
      r_pulse    <= '0;
      r_conflict <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_lo_cnt   <= w_lo_nxt;
      r_pulse    <= w_pulse_nxt;
      r_conflict <= w_conflict_nxt;
    end
  end

  assign N        = r_pulse[3];
  assign S        = r_pulse[2];
  assign E        = r_pulse[1];
  assign W        = r_pulse[0];
  assign CONFLICT = r_conflict;

endmodule

// File: tb/tb_direction_input_conditioner.sv
// Scoreboard bench for direction_input_conditioner: stimulus queues expected pulses
// (output vector and cycle), an independent monitor pops on every non-zero output.
module tb_direction_input_conditioner;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic btn_n = 1'b0, btn_s = 1'b0, btn_e = 1'b0, btn_w = 1'b0;
  logic N, S, E, W, CONFLICT;

  direction_input_conditioner #(.DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .btn_n(btn_n), .btn_s(btn_s), .btn_e(btn_e), .btn_w(btn_w),
    .N(N), .S(S), .E(E), .W(W), .CONFLICT(CONFLICT)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Output vector order: {CONFLICT, N, S, E, W}
  typedef struct {
    logic [4:0] vec;
    int         cyc_at;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;

  localparam int LAT = 7;

  function automatic void expect_pulse(input logic [4:0] v, input int t);
    exp_t e;
    e.vec = v;
    e.cyc_at = t;
    q.push_back(e);
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_btn(input logic [3:0] b);
    {btn_n, btn_s, btn_e, btn_w} = b;
  endtask

  task automatic check_zero(input string name);
    total++;
    if ({CONFLICT, N, S, E, W} !== 5'b0) begin
      bad++;
      $display("FAIL %s: outputs=%b required 00000 at cycle %0d", name, {CONFLICT, N, S, E, W}, cyc);
    end
  endtask

  always @(negedge clk) begin
    logic [4:0] o;
    exp_t e;
    o = {CONFLICT, N, S, E, W};
    if (o !== 5'b0) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_pulse: got %b at cycle %0d, required none", o, cyc);
      end else begin
        e = q.pop_front();
        if (o !== e.vec || cyc != e.cyc_at) begin
          bad++;
          $display("FAIL pulse: got %b at cycle %0d, required %b at cycle %0d", o, cyc, e.vec, e.cyc_at);
        end
      end
    end
  end

  initial begin
    set_btn(4'b0000);
    reset = 1'b1;
    step(3);
    reset = 1'b0;
    check_zero("reset_state");
    step(12);

    // clean press on N
    set_btn(4'b1000); expect_pulse(5'b01000, cyc + LAT);
    step(20); set_btn(4'b0000); step(15);

    // bounce on E (3 high / 1 low) must not qualify, then a clean hold does
    for (int k = 0; k < 5; k++) begin
      set_btn(4'b0010); step(3);
      set_btn(4'b0000); step(1);
    end
    step(12);
    set_btn(4'b0010); expect_pulse(5'b00010, cyc + LAT);
    step(8); set_btn(4'b0000); step(15);

    // simultaneous E+W -> CONFLICT only, then W alone
    set_btn(4'b0011); expect_pulse(5'b10000, cyc + LAT);
    step(10); set_btn(4'b0000); step(15);
    set_btn(4'b0001); expect_pulse(5'b00001, cyc + LAT);
    step(10); set_btn(4'b0000); step(15);

    // overlapped: S pressed 3 cycles after the N pulse is ignored
    set_btn(4'b1000); expect_pulse(5'b01000, cyc + LAT);
    step(10); set_btn(4'b1100); step(10); set_btn(4'b0000); step(15);
    set_btn(4'b0100); expect_pulse(5'b00100, cyc + LAT);
    step(10); set_btn(4'b0000); step(15);

    // W held through a one-cycle reset is absorbed
    set_btn(4'b0001); expect_pulse(5'b00001, cyc + LAT);
    step(10);
    reset = 1'b1; step(1); reset = 1'b0;
    check_zero("held_reset_clear");
    step(20); set_btn(4'b0000); step(15);
    set_btn(4'b0001); expect_pulse(5'b00001, cyc + LAT);
    step(10); set_btn(4'b0000); step(15);

    // reset on the edge that would register a pending E pulse
    set_btn(4'b0010); step(6);
    reset = 1'b1; step(1); reset = 1'b0;
    check_zero("reset_kills_pending");
    step(15); set_btn(4'b0000); step(15);

    // reset at edge 3 of S debounce
    set_btn(4'b0100); step(3);
    reset = 1'b1; step(1); reset = 1'b0;
    check_zero("reset_mid_debounce");
    step(15); set_btn(4'b0000); step(15);
    set_btn(4'b0100); expect_pulse(5'b00100, cyc + LAT);
    step(10); set_btn(4'b0000); step(20);

    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL missing_pulses: outstanding=%0d required 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/direction_input_conditioner.md
# direction_input_conditioner

Front-end stage that turns four raw, asynchronous, bouncing direction pushbuttons into clean single-cycle move pulses for `adventure_game`. Each button is synchronised and debounced. Each press gesture produces at most one pulse. Its `N`, `S`, `E`, `W` outputs connect directly to the game FSM inputs of the same names.

## Interface
- `DEBOUNCE_CYCLES`, default 4, range ≥1: consecutive synchronised samples that must disagree with the debounced level before that level flips.
- `clk` input 1: single system clock; all logic is on its rising edge.
- `reset` input 1: synchronous, active-high reset.
- `btn_n`, `btn_s`, `btn_e`, `btn_w` input 1 each: raw button levels, active-high, asynchronous to `clk`.
- `N`, `S`, `E`, `W` output 1 each: registered one-cycle move pulses, at most one high in any cycle.
- `CONFLICT` output 1: registered one-cycle pulse when a gesture is rejected because more than one button qualified in the same cycle.

## Operation
- Synchroniser: each button passes through a 2-flop synchroniser, `s1` then `s2`. Only `s2` is used downstream.
- Debounce, per button:
  - State is level `db` plus counter `cnt`.
  - If `s2 == db`: `cnt` returns to 0.
  - Otherwise `cnt` increments. When the increment would reach `DEBOUNCE_CYCLES`, `db` takes the value of `s2` and `cnt` returns to 0 on that same edge.
  - Counter width is `$clog2(DEBOUNCE_CYCLES+3)`. `cnt` never wraps.
- Qualifying press: `db` is 1 while the FSM is in IDLE.
- FSM states:
  - **LOCKOUT**, the reset state.
    - A lockout counter runs for `DEBOUNCE_CYCLES+2` cycles after reset deasserts.
    - On expiry: go to HELD if any `db` = 1, otherwise go to IDLE.
    - No pulses are issued in this state.
  - **IDLE**
    - Exactly one `db` high: register a pulse on the matching output and go to HELD.
    - Two or more `db` high in the same cycle: register a `CONFLICT` pulse, no direction pulse, and go to HELD.
    - No `db` high: stay in IDLE.
  - **HELD**
    - Go to IDLE only when all four `db` are 0.
    - Any new press while in HELD is ignored, including a press on a different button.
- Outputs are registered. Each is high for exactly one cycle per accepted gesture and never stays high two cycles in a row.
- Reset, asserted in any cycle:
  - Clears `s1`, `s2`, `db`, `cnt` and the lockout counter.
  - Forces the FSM to LOCKOUT.
  - Drives all outputs to 0 on the next edge, including a pulse that was pending for that edge.
  - A button held through reset yields no pulse: it is debounced during LOCKOUT and absorbed into HELD.

## Timing
- Reset values: `N`=`S`=`E`=`W`=`CONFLICT`=0. The FSM is in LOCKOUT.
- Press latency, with edge 0 = first edge that samples the raw button high, held steady:
  - `s2` = 1 after edge 1.
  - `db` = 1 after edge `DEBOUNCE_CYCLES+1`.
  - The pulse is high during the cycle following edge `DEBOUNCE_CYCLES+2`.
  - With the default of 4, the pulse follows edge 6, i.e. 7 edges of latency.
- Release latency: all `db` reach 0 `DEBOUNCE_CYCLES+1` edges after release is first sampled. HELD→IDLE happens on the next edge.
- Minimum gesture period is 2·(`DEBOUNCE_CYCLES`+2) cycles, i.e. 12 cycles at the default.
- A bounce shorter than `DEBOUNCE_CYCLES` consecutive `s2` samples never changes `db`.
- Buttons that qualify in different cycles are not a conflict: the first one wins and the later one is ignored because the FSM is in HELD.
- After reset deasserts, the earliest possible pulse follows edge `DEBOUNCE_CYCLES+3`, counting from the first edge with `reset`=0.

## Test plan
- **Clean press.** Reset, wait 10 cycles. Hold `btn_n`=1 for 20 cycles, then release. Required: `N`=1 for exactly one cycle, following edge 6 after the press. `S`, `E`, `W` and `CONFLICT` stay 0 throughout.
- **Bounce rejection.** Toggle `btn_e` high 3 cycles / low 1 cycle, five times, then low. Required: no output pulse. Then hold `btn_e` high 8 cycles. Required: a single `E` pulse.
- **Simultaneous press.** Raise `btn_e` and `btn_w` on the same edge and hold both 10 cycles. Required: one `CONFLICT` pulse at edge 6 and no direction pulse. After both are released, and 12 or more cycles later, press `btn_w` alone. Required: a single `W` pulse.
- **Overlapped press.** Hold `btn_n`, then 3 cycles after the `N` pulse also press `btn_s`. Hold both 10 cycles. Required: no `S` pulse and no `CONFLICT`. Release both, then press `btn_s`. Required: a single `S` pulse.
- **Held through reset.** With `btn_w` held, assert `reset` for 1 cycle. Keep `btn_w` held for 20 more cycles. Required: all outputs stay 0. Release, wait, and press again. Required: a `W` pulse.
- **Reset mid-debounce.** Raise `btn_s` and assert `reset` at edge 3 of the debounce. Required: all outputs 0 on the next edge, and no `S` pulse until the button qualifies again after LOCKOUT.
